// File: rtl/crc_pkg.sv
// Shared CRC-8 constants and types for the serial CRC generator and checker.
package crc_pkg;

  localparam int unsigned CRC_W          = 8;
  localparam logic [CRC_W-1:0] CRC_POLY  = 8'h1D;
  localparam int unsigned MIN_FRAME_BITS = 9;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } crc_state_t;

endpackage : crc_pkg

// File: rtl/crc8_step.sv
// One MSB-first CRC-8 LFSR step; shared by generator and checker so both ends divide identically.
module crc8_step
  import crc_pkg::*;
(
  input  logic [CRC_W-1:0] r,
  input  logic             nextbit,
  output logic [CRC_W-1:0] r_next
);

  logic inv;

  always_comb begin
    inv    = nextbit ^ r[CRC_W-1];
    r_next = {r[CRC_W-2:0], 1'b0} ^ (inv ? CRC_POLY : CRC_W'(0));
  end

endmodule : crc8_step

// File: rtl/crc_check.sv
// Serial CRC-8 frame checker: divides payload+CRC by the generator polynomial and reports at frame end.
module crc_check
  import crc_pkg::*;
#(
  parameter int unsigned CNTW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             nextbit,
  input  logic             bitvalid,
  input  logic             lastbit,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             crcok,
  output logic             shortframe,
  output logic [CRC_W-1:0] syndrome,
  output logic [CNTW-1:0]  bitcount
);

  crc_state_t       state, state_n;
  logic [CRC_W-1:0] r, r_n, r_base, r_step;
  logic [CNTW-1:0]  cnt, cnt_n, cnt_base, cnt_inc;
  logic             busy_n, done_n, crcok_n, short_n;
  logic [CRC_W-1:0] syndrome_n;
  logic [CNTW-1:0]  bitcount_n;

  // A frame starting from IDLE is seeded from zero, not from stale state.
  assign r_base   = (state == IDLE) ? CRC_W'(0) : r;
  assign cnt_base = (state == IDLE) ? CNTW'(0)  : cnt;
  assign cnt_inc  = (cnt_base == {CNTW{1'b1}}) ? cnt_base : cnt_base + CNTW'(1);

  crc8_step u_step (
    .r       (r_base),
    .nextbit (nextbit),
    .r_next  (r_step)
  );

  always_comb begin
    state_n    = state;
    r_n        = r;
    cnt_n      = cnt;
    done_n     = 1'b0;
    crcok_n    = crcok;
    short_n    = shortframe;
    syndrome_n = syndrome;
    bitcount_n = bitcount;

    if (abort) begin
      state_n = IDLE;
      r_n     = '0;
      cnt_n   = '0;
    end else if (bitvalid) begin
      if (lastbit) begin
        state_n    = IDLE;
        r_n        = '0;
        cnt_n      = '0;
        done_n     = 1'b1;
        syndrome_n = r_step;
        bitcount_n = cnt_inc;
        short_n    = (32'(cnt_inc) < MIN_FRAME_BITS);
        crcok_n    = (r_step == CRC_W'(0)) && !(32'(cnt_inc) < MIN_FRAME_BITS);
      end else begin
        state_n = RECV;
        r_n     = r_step;
        cnt_n   = cnt_inc;
      end
    end

    busy_n = (state_n == RECV);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      r          <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      crcok      <= 1'b0;
      shortframe <= 1'b0;
      syndrome   <= '0;
      bitcount   <= '0;
    end else begin
      state      <= state_n;
      r          <= r_n;
      cnt        <= cnt_n;
      busy       <= busy_n;
      done       <= done_n;
      crcok      <= crcok_n;
      shortframe <= short_n;
      syndrome   <= syndrome_n;
      bitcount   <= bitcount_n;
    end
  end

endmodule : crc_check

// File: tb/tb_crc_check.sv
// Randomized self-checking bench for crc_check against a polynomial long-division model.
module tb_crc_check;

  localparam int unsigned CNTW = 8;
  localparam int unsigned MAXC = (1 << CNTW) - 1;

  typedef bit bitq_t[$];

  logic            clk = 1'b0;
  logic            reset;
  logic            nextbit, bitvalid, lastbit, abort;
  logic            busy, done, crcok, shortframe;
  logic [7:0]      syndrome;
  logic [CNTW-1:0] bitcount;

  int n_checks = 0;
  int n_pass   = 0;
  int done_seen = 0;
  int exp_dones = 0;

  crc_check #(.CNTW(CNTW)) dut (
    .clk        (clk),
    .reset      (reset),
    .nextbit    (nextbit),
    .bitvalid   (bitvalid),
    .lastbit    (lastbit),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .crcok      (crcok),
    .shortframe (shortframe),
    .syndrome   (syndrome),
    .bitcount   (bitcount)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // Syndrome = frame(x) * x^8 mod (x^8+x^4+x^3+x^2+1), by explicit long division.
  function automatic logic [7:0] ref_syn(input bitq_t q);
    bit         a[$];
    logic [8:0] g;
    logic [7:0] s;
    int         n;
    g = 9'h11D;
    a = q;
    n = q.size();
    for (int k = 0; k < 8; k++) a.push_back(1'b0);
    for (int i = 0; i < n; i++)
      if (a[i]) for (int j = 0; j < 9; j++) a[i+j] = a[i+j] ^ g[8-j];
    for (int k = 0; k < 8; k++) s[7-k] = a[n+k];
    return s;
  endfunction

  function automatic bitq_t add_byte(input bitq_t q, input logic [7:0] b);
    bitq_t r;
    r = q;
    for (int k = 7; k >= 0; k--) r.push_back(b[k]);
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic b, input logic l, input logic a);
    bitvalid = v; nextbit = b; lastbit = l; abort = a;
  endtask

  // Feed bits with optional random idle gaps; lastbit marks the final bit when fin is set.
  task automatic feed(input bitq_t q, input int gap_pct, input bit fin);
    for (int i = 0; i < q.size(); i++) begin
      for (int g = 0; g < 4 && gap_pct > 0 && $urandom_range(99) < gap_pct; g++) begin
        drive(1'b0, 1'($urandom), 1'($urandom), 1'b0);
        cycle();
        check("busy_gap", busy, (i > 0) ? 1 : 0);
        check("done_gap", done, 0);
      end
      drive(1'b1, q[i], fin && (i == q.size() - 1), 1'b0);
      cycle();
      if (!(fin && i == q.size() - 1)) check("busy_rx", busy, 1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_done(input string tag, input bitq_t q);
    logic [7:0] s;
    int         n, c;
    bit         sh;
    s  = ref_syn(q);
    n  = q.size();
    c  = (n > MAXC) ? MAXC : n;
    sh = (c < 9);
    exp_dones++;
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_syn"}, syndrome, s);
    check({tag, "_cnt"}, bitcount, c);
    check({tag, "_short"}, shortframe, sh);
    check({tag, "_ok"}, crcok, (s == 0) && !sh);
  endtask

  task automatic idle1();
    cycle();
    check("done_width", done, 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    bitq_t f, g, pl;
    logic  held_ok;
    int    nb;

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ok", crcok, 0);
    check("rst_short", shortframe, 0);
    check("rst_syn", syndrome, 0);
    check("rst_cnt", bitcount, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Known good frame.
    f = {}; f = add_byte(f, 8'h01); f = add_byte(f, 8'h1D);
    feed(f, 0, 1);
    expect_done("good", f);
    check("good_syn_k", syndrome, 8'h00);
    idle1();

    // Last bit flipped.
    f = {}; f = add_byte(f, 8'h01); f = add_byte(f, 8'h1C);
    feed(f, 0, 1);
    expect_done("flip", f);
    check("flip_syn_k", syndrome, 8'h1D);
    idle1();

    // Zero frame with gaps, then back-to-back frame starting in the done cycle.
    f = {}; f = add_byte(f, 8'h00); f = add_byte(f, 8'h00);
    feed(f, 40, 1);
    expect_done("zero", f);
    g = {}; g = add_byte(g, 8'h02); g = add_byte(g, 8'h3A);
    feed(g, 0, 1);
    expect_done("b2b", g);
    check("b2b_ok_k", crcok, 1);
    idle1();

    // Single-bit frame from IDLE.
    f = {1'b1};
    feed(f, 0, 1);
    expect_done("one", f);
    check("one_syn_k", syndrome, 8'h1D);
    idle1();

    // Abort after 5 bits, with a valid (even lastbit) bit in the abort cycle.
    held_ok = crcok;
    f = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    feed(f, 0, 0);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hold", crcok, held_ok);
    f = {}; f = add_byte(f, 8'h01); f = add_byte(f, 8'h1D);
    feed(f, 0, 1);
    expect_done("post_abort", f);
    idle1();

    // Asynchronous reset between edges mid-frame; tail forms a new frame.
    g = {};
    for (int i = 0; i < 7; i++) g.push_back(f[i]);
    feed(g, 0, 0);
    #3 reset = 1'b1;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_ok", crcok, 0);
    check("mrst_syn", syndrome, 0);
    check("mrst_cnt", bitcount, 0);
    #1 reset = 1'b0;
    g = {};
    for (int i = 7; i < f.size(); i++) g.push_back(f[i]);
    feed(g, 0, 1);
    expect_done("tail", g);
    idle1();

    // Random frames: correct CRC appended, sometimes corrupted.
    for (int t = 0; t < 20; t++) begin
      pl = {};
      nb = $urandom_range(1, 4);
      for (int k = 0; k < nb; k++) pl = add_byte(pl, 8'($urandom));
      f = add_byte(pl, ref_syn(pl));
      if ($urandom_range(2) == 0) begin
        int p;
        p = $urandom_range(f.size() - 1);
        f[p] = ~f[p];
      end
      feed(f, 30, 1);
      expect_done("rnd", f);
      if ($urandom_range(1) == 0) idle1();
    end

    // Long frame past counter saturation.
    pl = {};
    for (int k = 0; k < 40; k++) pl = add_byte(pl, 8'($urandom));
    f = add_byte(pl, ref_syn(pl));
    feed(f, 0, 1);
    expect_done("sat", f);
    idle1();

    cycle();
    check("done_pulses", done_seen, exp_dones);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_crc_check
